// File: rtl/sev_seg_scan_ctrl_if.sv
// Frame-load handshake bundle for sev_seg_scan_ctrl: packed digit codes plus valid/ready.
interface sev_seg_scan_ctrl_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   logic [5*NUM_DIGITS-1:0] in_Values;
   logic                    in_Valid;
   logic                    out_Ready;

   modport master (output in_Values, output in_Valid, input out_Ready);
   modport slave  (input in_Values, input in_Valid, output out_Ready);
endinterface

// File: rtl/sev_seg_scan_ctrl.sv
// Seven-segment scan controller: double-buffered frame, blanked digit slots, frame-boundary commit.
// Optional PWM brightness control is enabled by defining SEV_SEG_BRIGHTNESS_EN.
module sev_seg_scan_ctrl #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned PRESCALE     = 1000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   sev_seg_scan_ctrl_if.slave    frame_bus,
`ifdef SEV_SEG_BRIGHTNESS_EN
   input  logic [3:0]            in_Bright,
`endif
   output logic [4:0]            out_Number,
   output logic [NUM_DIGITS-1:0] out_Anode,
   output logic                  out_FrameStart
);
   localparam int unsigned CW = $clog2(PRESCALE);
   localparam int unsigned IW = $clog2(NUM_DIGITS);
   localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

   typedef enum logic {BLANK, DRIVE} state_t;

   state_t                  state, state_nxt;
   logic [CW-1:0]           cnt, cnt_nxt;
   logic [IW-1:0]           idx, idx_nxt;
   logic                    run;
   logic                    pending;
   logic [4:0]              disp_buf [NUM_DIGITS];
   logic [4:0]              pend_buf [NUM_DIGITS];
   logic                    wrap, frame_wrap, commit, accept, lit;
   logic [4:0]              num_nxt;
   logic [NUM_DIGITS-1:0]   anode_nxt;
`ifdef SEV_SEG_BRIGHTNESS_EN
   logic [3:0]              pwm, pwm_nxt, bright;
`endif

   assign frame_bus.out_Ready = ~pending;

   // Outputs are registered from next-cycle values so they line up with cnt/idx.
   always_comb begin
      wrap       = run && (cnt == CNT_LAST);
      frame_wrap = wrap && (idx == IDX_LAST);
      commit     = frame_wrap && pending;
      accept     = frame_bus.in_Valid && !pending;
      cnt_nxt    = cnt;
      idx_nxt    = idx;
      if (wrap) begin
         cnt_nxt = '0;
         idx_nxt = frame_wrap ? '0 : idx + 1'b1;
      end else if (run) begin
         cnt_nxt = cnt + 1'b1;
      end

      state_nxt = state;
      unique case (state)
         BLANK: if (cnt_nxt == BLANK_END) state_nxt = DRIVE;
         DRIVE: if (wrap) state_nxt = BLANK;
      endcase

      num_nxt = out_Number;
      if (wrap) num_nxt = commit ? pend_buf[0] : disp_buf[idx_nxt];

      lit = (state_nxt == DRIVE);
`ifdef SEV_SEG_BRIGHTNESS_EN
      pwm_nxt = pwm + 4'd1;
      lit     = lit && (pwm_nxt <= bright);
`endif
      anode_nxt = '1;
      if (lit) anode_nxt[idx_nxt] = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= BLANK;
         cnt            <= '0;
         idx            <= '0;
         run            <= 1'b0;
         pending        <= 1'b0;
         out_Number     <= '0;
         out_Anode      <= '1;
         out_FrameStart <= 1'b0;
         for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            disp_buf[i] <= '0;
            pend_buf[i] <= '0;
         end
      end else begin
         // The first edge after reset only arms the scan so slot 0 opens with a frame-start pulse.
         run            <= 1'b1;
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         idx            <= idx_nxt;
         out_Number     <= num_nxt;
         out_Anode      <= anode_nxt;
         out_FrameStart <= !run || frame_wrap;
         if (accept) begin
            pending <= 1'b1;
            for (int unsigned i = 0; i < NUM_DIGITS; i++)
               pend_buf[i] <= frame_bus.in_Values[5*i +: 5];
         end else if (commit) begin
            pending <= 1'b0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++)
               disp_buf[i] <= pend_buf[i];
         end
      end
   end

`ifdef SEV_SEG_BRIGHTNESS_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pwm    <= '0;
         bright <= 4'd15;
      end else begin
         pwm <= pwm_nxt;
         if (out_FrameStart) bright <= in_Bright;
      end
   end
`endif

endmodule
